alu_muldiv_seq: RTL
===================

Name: alu_muldiv_seq

Overview:
- Parametrised, multi-cycle multiply/divide unit that sits beside the combinational ALU in the execute stage.
- Serves the extended-core MULWF/MULLW-class and divide instructions.
- Takes W and a literal or register-file operand and runs a shift-add multiply or restoring divide, one bit per clock.
- Reports through a start/busy/done handshake and returns a double-width result plus status flags for the status register.

Parameters:
- WIDTH, 8, operand width in bits; result is 2*WIDTH (hi/lo halves); legal range 4..32.
- SIGNED_EN, 1, 1 enables op 01 (signed multiply); 0 makes op 01 behave as illegal.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled on rising clk, accepted only when busy=0.
- abort  in  1  synchronous cancel; returns to IDLE, result registers unchanged.
- op  in  2  00 MULU, 01 MULS, 10 DIVU, 11 illegal.
- op_w  in  WIDTH  W operand (multiplicand / divisor).
- op_lf  in  WIDTH  literal or file operand (multiplier / dividend).
- status_en  in  1  captured at start; gates status_wr_en.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse in DONE.
- result_hi  out  WIDTH  MUL: product[2W-1:W]; DIVU: remainder.
- result_lo  out  WIDTH  MUL: product[W-1:0]; DIVU: quotient.
- flag_z  out  1  zero flag, valid with done.
- flag_err  out  1  divide-by-zero or illegal op, valid with done.
- status_wr_en  out  1  done AND captured status_en.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State IDLE.
  - busy, done, status_wr_en, flag_z, flag_err = 0.
  - result_hi, result_lo = 0.
  - Internal accumulators and counter = 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 captures op, op_w, op_lf, status_en.
  - Loads the bit counter with WIDTH and moves to RUN.
  - op=11, or op=01 with SIGNED_EN=0, goes straight to DONE with result 0 and flag_err=1.
- RUN: one iteration per clock; the counter decrements each iteration. After the WIDTH-th iteration the unit moves to DONE.
  - done rises WIDTH edges after the accepting edge (8 cycles at WIDTH=8).
- DONE: lasts exactly one cycle. done=1, status_wr_en=done&status_en_q. Then:
  - start=1 is accepted as in IDLE (back-to-back issue; the new operands are captured).
  - Otherwise the unit returns to IDLE.
- Result registers and flags are updated only on the edge entering DONE and hold until the next entry to DONE.
- start while busy=1 is ignored; no queuing.
- abort=1 in RUN: next edge goes to IDLE with no done pulse. abort has priority over completion on the same edge. abort outside RUN has no effect.
- rst_n low mid-operation: immediate return to reset values; no done.
- MULU: unsigned shift-add over a 2W accumulator. Exact product, no overflow.
- MULS: two's complement operands.
  - Magnitudes are multiplied unsigned.
  - The 2W product is negated on the DONE edge if the operand signs differ.
  - -2^(W-1) * -2^(W-1) = +2^(2W-2) exactly.
- DIVU: restoring division of op_lf by op_w, shifting the quotient in from the LSB; the remainder is always < divisor.
- Divide by zero (op_w=0): full latency is still used, with quotient = all ones, remainder = op_lf, flag_err=1.
- flag_z:
  - MUL: 1 iff the full 2W product is 0.
  - DIVU: 1 iff quotient = 0.
  - Illegal op: 1.
- flag_err = 0 for all legal, non-zero-divisor operations.
- Operand inputs may change freely after the accepting edge; only the captured copies are used.

Test Plan:
- WIDTH=8, MULU 0xFF x 0xFF -> done exactly 8 edges after accept, result_hi=0xFE, result_lo=0x01, flag_z=0, flag_err=0, busy high for 8 cycles.
- MULS op_lf=0xFE (-2), op_w=0x03 -> {hi,lo}=0xFFFA. MULS 0x80 x 0x80 -> 0x4000. With SIGNED_EN=0, op 01 -> next-cycle done, result 0, flag_err=1, flag_z=1.
- DIVU op_lf=200, op_w=7 -> result_lo=0x1C, result_hi=0x04, flag_z=0. op_lf=5, op_w=9 -> quotient 0, remainder 5, flag_z=1.
- DIVU op_lf=0x5A, op_w=0 -> after 8 cycles result_lo=0xFF, result_hi=0x5A, flag_err=1. status_en=1 -> status_wr_en pulses with done; status_en=0 -> it stays 0.
- Handshake:
  - start re-asserted on cycles 3 and 5 of RUN -> ignored, result from the first operation only.
  - start held in the DONE cycle -> the second operation runs with no IDLE gap; results 0xFE01 then the new product.
- abort on RUN cycle 4 -> no done, busy drops next edge, previous result registers unchanged.
- rst_n pulsed low mid-RUN -> all outputs 0 asynchronously, and a fresh start completes normally.

Source files
------------

// File: rtl/alu_muldiv_seq.sv
// Sequential multiply/divide unit: shift-add MULU/MULS and restoring DIVU, one bit per clock.
// A start/busy/done handshake returns a 2*WIDTH result with zero and error flags.
module alu_muldiv_seq #(
    parameter int WIDTH     = 8,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] op_w,
    input  logic [WIDTH-1:0] op_lf,
    input  logic             status_en,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_hi,
    output logic [WIDTH-1:0] result_lo,
    output logic             flag_z,
    output logic             flag_err,
    output logic             status_wr_en
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [1:0]         op_q;
    logic [WIDTH-1:0]   w_q;
    logic [2*WIDTH-1:0] acc;
    logic               neg_q;
    logic               status_en_q;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_trial;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] step_next;
    logic [2*WIDTH-1:0] final_res;
    logic               is_muls;
    logic               illegal;
    logic [WIDTH-1:0]   w_mag;
    logic [WIDTH-1:0]   lf_mag;

    always_comb begin
        is_muls = (op == 2'b01) && SIGNED_EN;
        illegal = (op == 2'b11) || ((op == 2'b01) && !SIGNED_EN);
        w_mag   = (is_muls && op_w[WIDTH-1])  ? -op_w  : op_w;
        lf_mag  = (is_muls && op_lf[WIDTH-1]) ? -op_lf : op_lf;

        // acc = {high accumulator, multiplier bits still to consume}
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, w_q} : '0);
        mul_next = {mul_sum, acc[WIDTH-1:1]};

        // acc = {partial remainder, dividend bits / quotient bits}; bit WIDTH of the trial is the borrow
        div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_trial = div_shift - {1'b0, w_q};
        if (div_trial[WIDTH])
            div_next = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        else
            div_next = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

        step_next = (op_q == 2'b10) ? div_next : mul_next;
        final_res = neg_q ? -step_next : step_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            op_q         <= '0;
            w_q          <= '0;
            acc          <= '0;
            neg_q        <= 1'b0;
            status_en_q  <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            result_hi    <= '0;
            result_lo    <= '0;
            flag_z       <= 1'b0;
            flag_err     <= 1'b0;
            status_wr_en <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done         <= 1'b0;
                    status_wr_en <= 1'b0;
                    state        <= IDLE;
                    if (start) begin
                        op_q        <= op;
                        status_en_q <= status_en;
                        w_q         <= w_mag;
                        acc         <= {{WIDTH{1'b0}}, lf_mag};
                        neg_q       <= is_muls && (op_w[WIDTH-1] ^ op_lf[WIDTH-1]);
                        cnt         <= WIDTH[CW-1:0];
                        if (illegal) begin
                            state        <= DONE;
                            done         <= 1'b1;
                            status_wr_en <= status_en;
                            result_hi    <= '0;
                            result_lo    <= '0;
                            flag_z       <= 1'b1;
                            flag_err     <= 1'b1;
                        end else begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        acc <= step_next;
                        cnt <= cnt - 1'b1;
                        if (cnt == CW'(1)) begin
                            state        <= DONE;
                            busy         <= 1'b0;
                            done         <= 1'b1;
                            status_wr_en <= status_en_q;
                            result_hi    <= final_res[2*WIDTH-1:WIDTH];
                            result_lo    <= final_res[WIDTH-1:0];
                            flag_z       <= (op_q == 2'b10) ? (final_res[WIDTH-1:0] == '0)
                                                            : (final_res == '0);
                            flag_err     <= (op_q == 2'b10) && (w_q == '0);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end
endmodule
